// File: rtl/snow64_bfloat16_vec_binop_dispatch.sv
// Serialises the enabled BFloat16 lanes of one vector command onto a single shared multi-cycle binop unit.
// Optional macro SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN adds in_op_sub, which negates every issued b lane.
module snow64_bfloat16_vec_binop_dispatch #(
   parameter int NUM_LANES   = 4,
   parameter int WIDTH__LANE = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_start,
   input  logic [NUM_LANES*WIDTH__LANE-1:0] in_a,
   input  logic [NUM_LANES*WIDTH__LANE-1:0] in_b,
   input  logic [NUM_LANES-1:0]             in_lane_mask,
`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
   input  logic                             in_op_sub,
`endif
   output logic                             out_can_accept_cmd,
   output logic                             out_data_valid,
   output logic [NUM_LANES*WIDTH__LANE-1:0] out_data,
   output logic                             out_binop_start,
   output logic [WIDTH__LANE-1:0]           out_binop_a,
   output logic [WIDTH__LANE-1:0]           out_binop_b,
   input  logic                             in_binop_data_valid,
   input  logic                             in_binop_can_accept_cmd,
   input  logic [WIDTH__LANE-1:0]           in_binop_data
);
   localparam int VEC_W = NUM_LANES * WIDTH__LANE;
   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StIssue,
      StWait,
      StDone
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [VEC_W-1:0]       a_q, a_d;
   logic [VEC_W-1:0]       b_q, b_d;
   logic [NUM_LANES-1:0]   mask_q, mask_d;
   logic [VEC_W-1:0]       result_q, result_d;
   logic [VEC_W-1:0]       out_data_q, out_data_d;
   logic                   data_valid_q, data_valid_d;
   logic [WIDTH__LANE-1:0] binop_a_q, binop_a_d;
   logic [WIDTH__LANE-1:0] binop_b_q, binop_b_d;
   logic                   wait_armed_q, wait_armed_d;

   logic [WIDTH__LANE-1:0] lane_a;
   logic [WIDTH__LANE-1:0] lane_b;
   logic [WIDTH__LANE-1:0] lane_b_issue;
   logic                   last_lane;

   assign lane_a    = a_q[int'(idx_q)*WIDTH__LANE +: WIDTH__LANE];
   assign lane_b    = b_q[int'(idx_q)*WIDTH__LANE +: WIDTH__LANE];
   assign last_lane = (idx_q == LAST_IDX);

`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
   logic sub_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else if (state_q == StIdle && in_start) begin
         sub_q <= in_op_sub;
      end
   end

   // Flipping the sign of b turns the shared adder into a subtractor.
   assign lane_b_issue = {lane_b[WIDTH__LANE-1] ^ sub_q, lane_b[WIDTH__LANE-2:0]};
`else
   assign lane_b_issue = lane_b;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mask_q       <= '0;
         result_q     <= '0;
         out_data_q   <= '0;
         data_valid_q <= 1'b0;
         binop_a_q    <= '0;
         binop_b_q    <= '0;
         wait_armed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         a_q          <= a_d;
         b_q          <= b_d;
         mask_q       <= mask_d;
         result_q     <= result_d;
         out_data_q   <= out_data_d;
         data_valid_q <= data_valid_d;
         binop_a_q    <= binop_a_d;
         binop_b_q    <= binop_b_d;
         wait_armed_q <= wait_armed_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      a_d          = a_q;
      b_d          = b_q;
      mask_d       = mask_q;
      result_d     = result_q;
      out_data_d   = out_data_q;
      data_valid_d = 1'b0;
      binop_a_d    = binop_a_q;
      binop_b_d    = binop_b_q;
      wait_armed_d = wait_armed_q;

      case (state_q)
         StIdle: begin
            if (in_start) begin
               a_d     = in_a;
               b_d     = in_b;
               mask_d  = in_lane_mask;
               idx_d   = '0;
               state_d = StSelect;
            end
         end
         StSelect: begin
            if (mask_q[idx_q]) begin
               // Operands are registered here so they are stable for the whole StIssue stall.
               binop_a_d = lane_a;
               binop_b_d = lane_b_issue;
               state_d   = StIssue;
            end else begin
               result_d[int'(idx_q)*WIDTH__LANE +: WIDTH__LANE] = lane_a;
               if (last_lane) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StIssue: begin
            if (in_binop_can_accept_cmd) begin
               wait_armed_d = 1'b0;
               state_d      = StWait;
            end
         end
         StWait: begin
            // The first wait cycle may still see the previous op's valid, so it is skipped.
            wait_armed_d = 1'b1;
            if (wait_armed_q && in_binop_data_valid) begin
               result_d[int'(idx_q)*WIDTH__LANE +: WIDTH__LANE] = in_binop_data;
               if (last_lane) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = StSelect;
               end
            end
         end
         StDone: begin
            out_data_d   = result_q;
            data_valid_d = 1'b1;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      out_can_accept_cmd = (state_q == StIdle);
      out_binop_start    = (state_q == StIssue) && in_binop_can_accept_cmd;
   end

   assign out_data_valid = data_valid_q;
   assign out_data       = out_data_q;
   assign out_binop_a    = binop_a_q;
   assign out_binop_b    = binop_b_q;
endmodule

// File: tb/tb_snow64_bfloat16_vec_binop_dispatch.sv
// Bench for snow64_bfloat16_vec_binop_dispatch with a latency-3 BFloat16 adder model (table of known sums).
// Honours SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN by connecting in_op_sub and running the subtract vector.
module tb_snow64_bfloat16_vec_binop_dispatch;
   localparam int NL = 4;
   localparam int VW = NL * 16;

   localparam logic [VW-1:0] A1 = {16'hBF80, 16'h3F00, 16'h4000, 16'h3F80};
   localparam logic [VW-1:0] B1 = {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
   localparam logic [VW-1:0] E1 = {16'h0000, 16'h3FC0, 16'h4040, 16'h4000};
   localparam logic [VW-1:0] E2 = {16'hBF80, 16'h3FC0, 16'h4000, 16'h4000};
   localparam logic [VW-1:0] A3 = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_start = 1'b0;
   logic [VW-1:0] in_a = '0;
   logic [VW-1:0] in_b = '0;
   logic [NL-1:0] in_lane_mask = '0;
`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
   logic          in_op_sub = 1'b0;
`endif
   logic          out_can_accept_cmd;
   logic          out_data_valid;
   logic [VW-1:0] out_data;
   logic          out_binop_start;
   logic [15:0]   out_binop_a;
   logic [15:0]   out_binop_b;

   logic        bu_valid = 1'b0;
   logic [15:0] bu_data = 16'h0;
   logic        bu_can_accept;
   logic        bu_hold = 1'b0;
   logic        stale_mode = 1'b0;
   int          bu_cnt = 0;
   logic [15:0] bu_res = 16'h0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t0 = 0;
   logic [VW-1:0] exp_data_q[$];
   logic [31:0]   exp_iss_q[$];
   logic          prev_start = 1'b0;

   always #5 clk = ~clk;

   snow64_bfloat16_vec_binop_dispatch #(
      .NUM_LANES  (NL),
      .WIDTH__LANE(16)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .in_start               (in_start),
      .in_a                   (in_a),
      .in_b                   (in_b),
      .in_lane_mask           (in_lane_mask),
`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
      .in_op_sub              (in_op_sub),
`endif
      .out_can_accept_cmd     (out_can_accept_cmd),
      .out_data_valid         (out_data_valid),
      .out_data               (out_data),
      .out_binop_start        (out_binop_start),
      .out_binop_a            (out_binop_a),
      .out_binop_b            (out_binop_b),
      .in_binop_data_valid    (bu_valid),
      .in_binop_can_accept_cmd(bu_can_accept),
      .in_binop_data          (bu_data)
   );

   function automatic logic [15:0] bf16_add_lut(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h3F80_3F80: return 16'h4000;
         32'h4000_3F80: return 16'h4040;
         32'h3F00_3F80: return 16'h3FC0;
         32'hBF80_3F80: return 16'h0000;
         32'h4040_BF80: return 16'h4000;
         default:       return 16'hDEAD;
      endcase
   endfunction

   // Adder model: result valid 3 cycles after start; stale mode keeps garbage valid up outside the result slot.
   assign bu_can_accept = (bu_cnt == 0) && !bu_hold;

   always @(posedge clk) begin
      bu_valid <= stale_mode;
      bu_data  <= 16'hBAD0;
      if (bu_cnt > 0) begin
         bu_cnt <= bu_cnt - 1;
         if (bu_cnt == 1) begin
            bu_valid <= 1'b1;
            bu_data  <= bu_res;
         end else begin
            bu_valid <= 1'b0;
         end
      end
      if (out_binop_start && bu_can_accept) begin
         bu_res <= bf16_add_lut(out_binop_a, out_binop_b);
         bu_cnt <= 2;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_data_valid) begin
            check("valid_expected", 64'(exp_data_q.size() != 0), 64'd1);
            if (exp_data_q.size() != 0) check("out_data", out_data, exp_data_q.pop_front());
         end
         if (out_binop_start) begin
            check("start_gap", 64'(prev_start), 64'd0);
            check("start_when_ready", 64'(bu_can_accept), 64'd1);
            check("issue_pending", 64'(exp_iss_q.size() != 0), 64'd1);
            if (exp_iss_q.size() != 0)
               check("issue_ab", {32'd0, out_binop_a, out_binop_b}, {32'd0, exp_iss_q.pop_front()});
         end
      end
      prev_start = out_binop_start;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_cmd(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [NL-1:0] mask,
                            input logic sub, input logic [VW-1:0] exp_out, input bit push_out,
                            input int iss_limit);
      int n;
      n = 0;
      in_a         = a;
      in_b         = b;
      in_lane_mask = mask;
      in_start     = 1'b1;
`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
      in_op_sub    = sub;
`endif
      for (int i = 0; i < NL; i++) begin
         if (mask[i] && n < iss_limit) begin
            exp_iss_q.push_back({a[i*16 +: 16], b[i*16+15] ^ sub, b[i*16 +: 15]});
            n++;
         end
      end
      if (push_out) exp_data_q.push_back(exp_out);
      t0 = cyc;
      step();
      in_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int k;
      k = 0;
      while (!out_data_valid && k < 300) begin
         step();
         k++;
      end
      check({name, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int nv, v1, v2;
      rst = 1'b1;
      repeat (3) step();
      check("rst_can_accept", 64'(out_can_accept_cmd), 64'd1);
      check("rst_data_valid", 64'(out_data_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_binop_start", 64'(out_binop_start), 64'd0);
      check("rst_binop_a", 64'(out_binop_a), 64'd0);
      check("rst_binop_b", 64'(out_binop_b), 64'd0);
      rst = 1'b0;
      repeat (2) step();

      start_cmd(A1, B1, 4'b1111, 1'b0, E1, 1'b1, 99);
      wait_done("full_mask", 22);

      start_cmd(A1, B1, 4'b0101, 1'b0, E2, 1'b1, 99);
      wait_done("mask_0101", 14);
      repeat (3) step();
      check("data_hold", out_data, E2);

      // Start held high: second command is taken only once StIdle comes back.
      in_a         = A3;
      in_b         = B1;
      in_lane_mask = '0;
      in_start     = 1'b1;
      exp_data_q.push_back(A3);
      exp_data_q.push_back(A3);
      nv = 0;
      v1 = 0;
      v2 = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 10) in_start = 1'b0;
         if (out_data_valid) begin
            nv++;
            if (nv == 1) v1 = i;
            else if (nv == 2) v2 = i;
         end
      end
      check("held_valid_count", 64'(nv), 64'd2);
      check("held_first_lat", 64'(v1), 64'd6);
      check("held_second_lat", 64'(v2), 64'd12);

      stale_mode = 1'b1;
      bu_hold    = 1'b1;
      start_cmd(A1, B1, 4'b1111, 1'b0, E1, 1'b1, 99);
      repeat (4) step();
      bu_hold = 1'b0;
      wait_done("stall_stale", 25);
      stale_mode = 1'b0;
      repeat (2) step();

`ifdef SNOW64_BFLOAT16_VEC_DISPATCH_SUB_EN
      start_cmd({4{16'h4040}}, {4{16'h3F80}}, 4'b1111, 1'b1, {4{16'h4000}}, 1'b1, 99);
      wait_done("sub", 22);
      in_op_sub = 1'b0;
      repeat (2) step();
`endif

      // Abort during the second wait cycle of lane 2; the lane-2 result arrives after reset.
      start_cmd(A1, B1, 4'b1111, 1'b0, E1, 1'b0, 3);
      repeat (13) step();
      rst = 1'b1;
      step();
      check("abort_can_accept", 64'(out_can_accept_cmd), 64'd1);
      check("abort_data_valid", 64'(out_data_valid), 64'd0);
      check("abort_out_data", out_data, 64'd0);
      rst = 1'b0;
      repeat (6) step();
      check("abort_data_stays", out_data, 64'd0);
      check("abort_idle", 64'(out_can_accept_cmd), 64'd1);

      start_cmd(A1, B1, 4'b0101, 1'b0, E2, 1'b1, 99);
      wait_done("after_reset", 14);
      repeat (3) step();

      check("data_queue_empty", 64'(exp_data_q.size()), 64'd0);
      check("issue_queue_empty", 64'(exp_iss_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
